// File: rtl/up_bus_aggregator_if.sv
// Register-bus bundle between an upstream master, the aggregator and its
// downstream register slaves. The "slave" modport is the aggregator's view
// (it accepts upstream requests and drives the slave broadcast). The "master"
// modport is the environment's view: the upstream requester plus the slaves.
interface up_bus_aggregator_if #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned ADDR_WIDTH = 14
);
  // upstream side
  logic                    up_wreq_in;
  logic                    up_rreq_in;
  logic [ADDR_WIDTH-1:0]   up_waddr_in;
  logic [ADDR_WIDTH-1:0]   up_raddr_in;
  logic [31:0]             up_wdata_in;
  logic                    up_wack_out;
  logic                    up_rack_out;
  logic [31:0]             up_rdata_out;
  // downstream broadcast side
  logic                    up_wreq;
  logic                    up_rreq;
  logic [ADDR_WIDTH-1:0]   up_waddr;
  logic [ADDR_WIDTH-1:0]   up_raddr;
  logic [31:0]             up_wdata;
  logic [NUM_SLAVES-1:0]   up_wack_s;
  logic [NUM_SLAVES-1:0]   up_rack_s;
  logic [32*NUM_SLAVES-1:0] up_rdata_s;

  modport slave (
    input  up_wreq_in, up_rreq_in, up_waddr_in, up_raddr_in, up_wdata_in,
    output up_wack_out, up_rack_out, up_rdata_out,
    output up_wreq, up_rreq, up_waddr, up_raddr, up_wdata,
    input  up_wack_s, up_rack_s, up_rdata_s
  );

  modport master (
    output up_wreq_in, up_rreq_in, up_waddr_in, up_raddr_in, up_wdata_in,
    input  up_wack_out, up_rack_out, up_rdata_out,
    input  up_wreq, up_rreq, up_waddr, up_raddr, up_wdata,
    output up_wack_s, up_rack_s, up_rdata_s
  );
endinterface

// File: rtl/up_bus_aggregator.sv
// Fans one upstream register bus out to NUM_SLAVES register slaves and merges
// their acknowledges back. One request is outstanding at a time, with a
// one-deep pending slot for a request that arrives while busy. Requests the
// slaves never answer are force-acknowledged after TIMEOUT_CYCLES.
module up_bus_aggregator #(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned ADDR_WIDTH     = 14,
  parameter int unsigned TIMEOUT_CYCLES = 32,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEADDEAD
) (
  input  logic               up_clk,
  input  logic               up_rstn,
  up_bus_aggregator_if.slave bus,
  output logic [15:0]        up_timeout_count,
  output logic               up_multi_ack_err,
  output logic               up_busy
);

  typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT} state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                state;
  logic [15:0]           wait_cnt;
  logic                  pend_valid;
  logic                  pend_wr;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic [31:0]           pend_data;

  logic                  any_wack;
  logic                  any_rack;
  logic                  multi_wack;
  logic                  multi_rack;
  logic [31:0]           rack_data;
  logic                  new_req;
  logic [ADDR_WIDTH-1:0] new_addr;
  logic                  timed_out;
  logic [15:0]           tcount_next;

  // Reduce per-slave acks: any responder, more than one, OR of acking slaves' data
  always_comb begin
    any_wack   = 1'b0;
    any_rack   = 1'b0;
    multi_wack = 1'b0;
    multi_rack = 1'b0;
    rack_data  = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (bus.up_wack_s[k]) begin
        multi_wack = multi_wack | any_wack;
        any_wack   = 1'b1;
      end
      if (bus.up_rack_s[k]) begin
        multi_rack = multi_rack | any_rack;
        any_rack   = 1'b1;
        rack_data  = rack_data | bus.up_rdata_s[32*k +: 32];
      end
    end
  end

  // Incoming-request selection for the pending slot (write wins) and timeout bookkeeping
  always_comb begin
    new_req     = bus.up_wreq_in | bus.up_rreq_in;
    new_addr    = bus.up_wreq_in ? bus.up_waddr_in : bus.up_raddr_in;
    timed_out   = (wait_cnt == WAIT_LAST);
    tcount_next = (up_timeout_count == 16'hFFFF) ? up_timeout_count
                                                 : up_timeout_count + 16'd1;
    up_busy     = (state != IDLE) | pend_valid;
  end

  // Request sequencing FSM; every bus output is registered here
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      state            <= IDLE;
      wait_cnt         <= '0;
      pend_valid       <= 1'b0;
      pend_wr          <= 1'b0;
      pend_addr        <= '0;
      pend_data        <= '0;
      bus.up_wreq      <= 1'b0;
      bus.up_rreq      <= 1'b0;
      bus.up_waddr     <= '0;
      bus.up_raddr     <= '0;
      bus.up_wdata     <= '0;
      bus.up_wack_out  <= 1'b0;
      bus.up_rack_out  <= 1'b0;
      bus.up_rdata_out <= '0;
      up_timeout_count <= '0;
      up_multi_ack_err <= 1'b0;
    end else begin
      bus.up_wreq      <= 1'b0;
      bus.up_rreq      <= 1'b0;
      bus.up_wack_out  <= 1'b0;
      bus.up_rack_out  <= 1'b0;
      up_multi_ack_err <= 1'b0;

      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (pend_valid) begin
            if (pend_wr) begin
              bus.up_wreq  <= 1'b1;
              bus.up_waddr <= pend_addr;
              bus.up_wdata <= pend_data;
              state        <= WR_WAIT;
            end else begin
              bus.up_rreq  <= 1'b1;
              bus.up_raddr <= pend_addr;
              state        <= RD_WAIT;
            end
            // The slot empties as it issues, so a request arriving now refills it
            pend_valid <= new_req;
            pend_wr    <= bus.up_wreq_in;
            pend_addr  <= new_addr;
            pend_data  <= bus.up_wdata_in;
          end else if (bus.up_wreq_in) begin
            bus.up_wreq  <= 1'b1;
            bus.up_waddr <= bus.up_waddr_in;
            bus.up_wdata <= bus.up_wdata_in;
            state        <= WR_WAIT;
            // A read arriving with the write waits in the slot
            pend_valid   <= bus.up_rreq_in;
            pend_wr      <= 1'b0;
            pend_addr    <= bus.up_raddr_in;
          end else if (bus.up_rreq_in) begin
            bus.up_rreq  <= 1'b1;
            bus.up_raddr <= bus.up_raddr_in;
            state        <= RD_WAIT;
          end
        end

        WR_WAIT: begin
          if (any_wack) begin
            bus.up_wack_out  <= 1'b1;
            up_multi_ack_err <= multi_wack;
            state            <= IDLE;
          end else if (timed_out) begin
            bus.up_wack_out  <= 1'b1;
            up_timeout_count <= tcount_next;
            state            <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end

        RD_WAIT: begin
          if (any_rack) begin
            bus.up_rack_out  <= 1'b1;
            bus.up_rdata_out <= rack_data;
            up_multi_ack_err <= multi_rack;
            state            <= IDLE;
          end else if (timed_out) begin
            bus.up_rack_out  <= 1'b1;
            bus.up_rdata_out <= TIMEOUT_RDATA;
            up_timeout_count <= tcount_next;
            state            <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end

        default: state <= IDLE;
      endcase

      if ((state != IDLE) && !pend_valid && new_req) begin
        pend_valid <= 1'b1;
        pend_wr    <= bus.up_wreq_in;
        pend_addr  <= new_addr;
        pend_data  <= bus.up_wdata_in;
      end
    end
  end

endmodule

// File: tb/tb_up_bus_aggregator.sv
// Bench for up_bus_aggregator: table of directed transactions, randomized
// transactions checked against a transaction-level model, and hand-written
// sequences for request collision, pending-slot drop and mid-transaction reset.
`timescale 1ns/1ps
module tb_up_bus_aggregator;

  localparam int unsigned NS = 4;
  localparam int unsigned AW = 14;
  localparam int unsigned TO = 32;
  localparam logic [31:0] TO_RD = 32'hDEADDEAD;

  logic        up_clk = 1'b0;
  logic        up_rstn;
  logic [15:0] up_timeout_count;
  logic        up_multi_ack_err;
  logic        up_busy;

  up_bus_aggregator_if #(.NUM_SLAVES(NS), .ADDR_WIDTH(AW)) bus_if ();

  up_bus_aggregator #(
    .NUM_SLAVES(NS),
    .ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TO),
    .TIMEOUT_RDATA(TO_RD)
  ) dut (
    .up_clk(up_clk),
    .up_rstn(up_rstn),
    .bus(bus_if),
    .up_timeout_count(up_timeout_count),
    .up_multi_ack_err(up_multi_ack_err),
    .up_busy(up_busy)
  );

  always #5 up_clk = ~up_clk;

  typedef struct {
    logic             wr;
    logic [AW-1:0]    addr;
    logic [31:0]      wd;
    logic [NS-1:0]    mask;   // slaves that ack
    int unsigned      dly;    // ack cycle, counted from the downstream request cycle
    logic [32*NS-1:0] words;  // per-slave read data (non-ackers carry junk)
    logic [31:0]      exp_rd;
    logic             exp_err;
    logic             exp_to;
  } vec_t;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] last_rdata;
  logic [15:0] exp_tcnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic idle_inputs();
    bus_if.up_wreq_in  = 1'b0;
    bus_if.up_rreq_in  = 1'b0;
    bus_if.up_waddr_in = '0;
    bus_if.up_raddr_in = '0;
    bus_if.up_wdata_in = '0;
    bus_if.up_wack_s   = '0;
    bus_if.up_rack_s   = '0;
    bus_if.up_rdata_s  = '0;
  endtask

  // Transaction-level reference: accepted if some slave acks before the wait runs out
  function automatic vec_t ref_model(input vec_t v);
    vec_t r;
    logic hit;
    r         = v;
    hit       = (v.mask != '0) && (v.dly < TO);
    r.exp_to  = !hit;
    r.exp_err = hit && ($countones(v.mask) > 1);
    r.exp_rd  = TO_RD;
    if (hit) begin
      r.exp_rd = '0;
      for (int k = 0; k < int'(NS); k++)
        if (v.mask[k]) r.exp_rd = r.exp_rd | v.words[32*k +: 32];
    end
    if (v.wr) r.exp_rd = '0;
    return r;
  endfunction

  // One upstream request, slaves respond per the vector; starts and ends at a negedge
  task automatic do_txn(input vec_t v);
    int unsigned exp_cyc, n_ack, n_wrong, n_err, ack_cyc;
    logic        err_at_ack;
    logic [31:0] rd_at_ack;
    exp_cyc = v.exp_to ? TO : v.dly + 1;
    if (v.exp_to && exp_tcnt != 16'hFFFF) exp_tcnt++;
    n_ack = 0; n_wrong = 0; n_err = 0; ack_cyc = 0;
    err_at_ack = 1'b0; rd_at_ack = '0;

    bus_if.up_wreq_in  = v.wr;
    bus_if.up_rreq_in  = !v.wr;
    bus_if.up_waddr_in = v.addr;
    bus_if.up_raddr_in = v.addr;
    bus_if.up_wdata_in = v.wd;
    @(negedge up_clk);
    bus_if.up_wreq_in = 1'b0;
    bus_if.up_rreq_in = 1'b0;
    check("ds_req", 32'({bus_if.up_wreq, bus_if.up_rreq}), 32'({v.wr, !v.wr}));
    check("ds_addr", 32'(v.wr ? bus_if.up_waddr : bus_if.up_raddr), 32'(v.addr));
    if (v.wr) check("ds_wdata", bus_if.up_wdata, v.wd);
    check("busy_during", 32'(up_busy), 32'd1);

    for (int unsigned k = 0; k <= exp_cyc + 3; k++) begin
      if (v.wr ? bus_if.up_wack_out : bus_if.up_rack_out) begin
        n_ack++;
        ack_cyc    = k;
        rd_at_ack  = bus_if.up_rdata_out;
        err_at_ack = up_multi_ack_err;
      end
      if (v.wr ? bus_if.up_rack_out : bus_if.up_wack_out) n_wrong++;
      if (up_multi_ack_err) n_err++;
      bus_if.up_wack_s  = (v.wr && k == v.dly) ? v.mask : '0;
      bus_if.up_rack_s  = (!v.wr && k == v.dly) ? v.mask : '0;
      bus_if.up_rdata_s = v.words;
      @(negedge up_clk);
    end
    idle_inputs();

    check("ack_count", n_ack, 32'd1);
    check("wrong_ack", n_wrong, 32'd0);
    check("ack_latency", ack_cyc, exp_cyc);
    check("multi_err_count", n_err, 32'(v.exp_err));
    check("multi_err_with_ack", 32'(err_at_ack), 32'(v.exp_err));
    if (!v.wr) begin
      check("rdata", rd_at_ack, v.exp_rd);
      last_rdata = v.exp_rd;
    end
    check("rdata_hold", bus_if.up_rdata_out, last_rdata);
    check("timeout_count", 32'(up_timeout_count), 32'(exp_tcnt));
    check("busy_after", 32'(up_busy), 32'd0);
  endtask

  // Free-running sequence: upstream pulses per schedule bit, slaves ack one cycle after a request
  task automatic react(input logic [15:0] wr_sched, input logic [15:0] rd_sched,
                       input logic [31:0] rword,
                       output int unsigned n_wreq, output int unsigned n_rreq,
                       output int unsigned n_wack, output int unsigned n_rack,
                       output int unsigned c_wack, output int unsigned c_rreq,
                       output logic [31:0] rd_at_ack);
    logic pend_w, pend_r;
    n_wreq = 0; n_rreq = 0; n_wack = 0; n_rack = 0; c_wack = 0; c_rreq = 0;
    rd_at_ack = '0; pend_w = 1'b0; pend_r = 1'b0;
    for (int unsigned c = 0; c < 16; c++) begin
      if (bus_if.up_wreq) n_wreq++;
      if (bus_if.up_rreq) begin n_rreq++; c_rreq = c; end
      if (bus_if.up_wack_out) begin n_wack++; c_wack = c; end
      if (bus_if.up_rack_out) begin n_rack++; rd_at_ack = bus_if.up_rdata_out; end
      bus_if.up_wreq_in  = wr_sched[c];
      bus_if.up_rreq_in  = rd_sched[c];
      bus_if.up_waddr_in = 14'h0100;
      bus_if.up_raddr_in = 14'h0200;
      bus_if.up_wdata_in = 32'h0BAD_F00D;
      bus_if.up_wack_s   = pend_w ? 4'b0100 : 4'b0000;
      bus_if.up_rack_s   = pend_r ? 4'b0010 : 4'b0000;
      bus_if.up_rdata_s  = {32'h0, 32'h0, rword, 32'h0};
      pend_w = bus_if.up_wreq;
      pend_r = bus_if.up_rreq;
      @(negedge up_clk);
    end
    idle_inputs();
  endtask

  initial begin
    vec_t        tbl [9];
    vec_t        v;
    int unsigned n_wreq, n_rreq, n_wack, n_rack, c_wack, c_rreq, n_spur;
    logic [31:0] rd;

    //          wr    addr      wdata         mask     dly words                                                       exp_rd        err   to
    tbl[0] = '{1'b1, 14'h0010, 32'h12345678, 4'b0100, 1,  {32'h0, 32'h0, 32'h0, 32'h0},                               32'h0,        1'b0, 1'b0};
    tbl[1] = '{1'b0, 14'h0020, 32'h0,        4'b0010, 2,  {32'h0, 32'h0, 32'h0000ABCD, 32'h0},                        32'h0000ABCD, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 14'h0030, 32'h0,        4'b0000, 0,  {32'h0, 32'h0, 32'h0, 32'h0},                               TO_RD,        1'b0, 1'b1};
    tbl[3] = '{1'b0, 14'h0040, 32'h0,        4'b1001, 0,  {32'h00000F00, 32'h55550000, 32'h0000AAAA, 32'h000000F0},   32'h00000FF0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 14'h0050, 32'h0,        4'b0001, 31, {32'hFFFF0000, 32'h0, 32'h0, 32'h11223344},                 32'h11223344, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 14'h0060, 32'h0,        4'b0001, 32, {32'h0, 32'h0, 32'h0, 32'h11223344},                        TO_RD,        1'b0, 1'b1};
    tbl[6] = '{1'b1, 14'h3FFF, 32'hA5A5A5A5, 4'b0000, 0,  {32'h0, 32'h0, 32'h0, 32'h0},                               32'h0,        1'b0, 1'b1};
    tbl[7] = '{1'b1, 14'h0070, 32'h5A5A5A5A, 4'b1111, 3,  {32'h0, 32'h0, 32'h0, 32'h0},                               32'h0,        1'b1, 1'b0};
    tbl[8] = '{1'b0, 14'h0080, 32'h0,        4'b1111, 0,  {32'h8, 32'h4, 32'h2, 32'h1},                               32'h0000000F, 1'b1, 1'b0};

    idle_inputs();
    up_rstn    = 1'b1;
    last_rdata = '0;
    exp_tcnt   = '0;
    #1 up_rstn = 1'b0;
    repeat (2) @(negedge up_clk);
    check("rst_busy", 32'(up_busy), 32'd0);
    check("rst_tcount", 32'(up_timeout_count), 32'd0);
    check("rst_rdata", bus_if.up_rdata_out, 32'd0);
    check("rst_acks_reqs", 32'({bus_if.up_wack_out, bus_if.up_rack_out, bus_if.up_wreq,
                                bus_if.up_rreq, up_multi_ack_err}), 32'd0);
    up_rstn = 1'b1;
    @(negedge up_clk);

    for (int i = 0; i < 9; i++) do_txn(tbl[i]);

    for (int i = 0; i < 30; i++) begin
      v.wr    = 1'($urandom_range(0, 1));
      v.addr  = AW'($urandom);
      v.wd    = $urandom;
      v.mask  = NS'($urandom_range(0, 15));
      v.dly   = ($urandom_range(0, 3) == 0) ? $urandom_range(28, 36) : $urandom_range(0, 5);
      v.words = {$urandom, $urandom, $urandom, $urandom};
      v       = ref_model(v);
      do_txn(v);
    end

    // Simultaneous write and read: write first, read issued the cycle after the write ack
    react(16'h0001, 16'h0001, 32'hCAFE0001, n_wreq, n_rreq, n_wack, n_rack, c_wack, c_rreq, rd);
    check("coll_wreq_count", n_wreq, 32'd1);
    check("coll_rreq_count", n_rreq, 32'd1);
    check("coll_wack_count", n_wack, 32'd1);
    check("coll_rack_count", n_rack, 32'd1);
    check("coll_wack_cycle", c_wack, 32'd3);
    check("coll_rreq_after_wack", c_rreq, c_wack + 1);
    check("coll_rdata", rd, 32'hCAFE0001);

    // Read arrives mid-write and is held; a further write while the slot is full is dropped
    react(16'h0005, 16'h0002, 32'hCAFE0002, n_wreq, n_rreq, n_wack, n_rack, c_wack, c_rreq, rd);
    check("drop_wreq_count", n_wreq, 32'd1);
    check("drop_rreq_count", n_rreq, 32'd1);
    check("drop_wack_count", n_wack, 32'd1);
    check("drop_rack_count", n_rack, 32'd1);
    check("drop_rdata", rd, 32'hCAFE0002);
    last_rdata = 32'hCAFE0002;

    // Reset in the middle of a read wait
    bus_if.up_raddr_in = 14'h0055;
    bus_if.up_rreq_in  = 1'b1;
    @(negedge up_clk);
    bus_if.up_rreq_in = 1'b0;
    repeat (3) @(negedge up_clk);
    check("mid_busy", 32'(up_busy), 32'd1);
    #2 up_rstn = 1'b0;
    #1;
    check("mid_rst_busy", 32'(up_busy), 32'd0);
    check("mid_rst_rdata", bus_if.up_rdata_out, 32'd0);
    check("mid_rst_tcount", 32'(up_timeout_count), 32'd0);
    check("mid_rst_raddr", 32'(bus_if.up_raddr), 32'd0);
    exp_tcnt   = '0;
    last_rdata = '0;
    n_spur = 0;
    for (int unsigned c = 0; c < 6; c++) begin
      @(negedge up_clk);
      if (c == 1) up_rstn = 1'b1;
      if (bus_if.up_rack_out || bus_if.up_wack_out) n_spur++;
      bus_if.up_rack_s  = 4'b0010;
      bus_if.up_rdata_s = {4{32'h12340000}};
    end
    idle_inputs();
    @(negedge up_clk);
    if (bus_if.up_rack_out || bus_if.up_wack_out) n_spur++;
    check("mid_rst_no_ack", n_spur, 32'd0);
    check("mid_rst_rdata_held", bus_if.up_rdata_out, 32'd0);

    v = '{1'b0, 14'h0055, 32'h0, 4'b0010, 1, {32'h0, 32'h0, 32'h00C0FFEE, 32'h0}, 32'h0, 1'b0, 1'b0};
    do_txn(ref_model(v));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
